// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it for decode, and computes next PC on retire.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               retire,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, next_state;
  logic        load_instr;
  logic        do_retire;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    do_retire   = 1'b0;
    unique case (state)
      IDLE: next_state = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (retire) begin
          do_retire  = 1'b1;
          next_state = REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Jump outranks branch; branch target is word offset relative to pc+4.
  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump)                 next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)  next_pc = pc_plus4 + branch_off;
    else                      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_count <= '0;
    end else begin
      if (load_instr) instr <= imem_rdata;
      if (do_retire) begin
        pc          <= next_pc;
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized memory timing and controls
// checked against a plain-arithmetic PC/count model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  instr_count;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] m_pc;
  logic [3:0]  m_cnt;

  instr_fetch #(.RESET_PC(32'h0000_0000), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .retire(retire), .branch(branch), .jump(jump), .zero(zero),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = $signed(w[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; retire = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0; m_cnt = 4'd0;
  endtask

  task automatic fetch(input logic [31:0] word, input logic j, input logic b, input logic z,
                       input int unsigned waits, input int unsigned holds);
    int unsigned n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL req_timeout got=%b want=1", imem_req);
      return;
    end
    total++;
    if (imem_addr !== m_pc) begin
      bad++; $display("FAIL fetch_addr got=%h want=%h", imem_addr, m_pc);
    end
    for (int unsigned w = 0; w < waits; w++) begin
      imem_ack = 1'b0; imem_rdata = $urandom; retire = 1'($urandom);
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        bad++; $display("FAIL wait_stable req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                        imem_req, imem_addr, instr_valid, m_pc);
      end
    end
    // retire high alongside the ack must be ignored while fetching
    imem_ack = 1'b1; imem_rdata = word; retire = 1'($urandom);
    jump = 1'b1; branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; retire = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word || pc_plus4 !== m_pc + 32'd4) begin
      bad++; $display("FAIL hold_entry valid=%b req=%b instr=%h p4=%h want 1 0 %h %h",
                      instr_valid, imem_req, instr, pc_plus4, word, m_pc + 32'd4);
    end
    for (int unsigned h = 0; h < holds; h++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr !== word || pc !== m_pc) begin
        bad++; $display("FAIL hold_stable valid=%b instr=%h pc=%h want 1 %h %h",
                        instr_valid, instr, pc, word, m_pc);
      end
    end
    retire = 1'b1; jump = j; branch = b; zero = z; imem_ack = 1'($urandom);
    @(negedge clk);
    retire = 1'b0; imem_ack = 1'b0;
    m_pc  = model_next(m_pc, word, j, b, z);
    m_cnt = m_cnt + 4'd1;
    total++;
    if (pc !== m_pc || instr_count !== m_cnt || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL retire pc=%h cnt=%0d valid=%b req=%b want %h %0d 0 1",
                      pc, instr_count, instr_valid, imem_req, m_pc, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || pc_plus4 !== 32'h4 ||
        instr !== 32'h0 || pc !== 32'h0 || instr_count !== 4'd0) begin
      bad++; $display("FAIL reset_state req=%b valid=%b addr=%h p4=%h instr=%h cnt=%0d",
                      imem_req, instr_valid, imem_addr, pc_plus4, instr, instr_count);
    end
    rst_n = 1'b1; m_pc = 32'h0; m_cnt = 4'd0;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL idle_after_release req=%b want 0", imem_req);
    end
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    fetch($urandom, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) fetch($urandom, 1'b0, 1'b0, 1'b0, 2, $urandom_range(0, 2));
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd12 || instr_count !== 4'd3) begin
      bad++; $display("FAIL sequential addr=%h cnt=%0d want 0000000c 3", imem_addr, instr_count);
    end
  endtask

  task automatic test_branch();
    fetch({6'h02, 26'h10}, 1'b1, 1'b0, 1'b0, 0, 0);
    fetch({6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b1, 1'b1, 1, 0);
    total++;
    if (pc !== 32'h3C) begin bad++; $display("FAIL beq_taken pc=%h want 0000003c", pc); end
    fetch({6'h02, 26'h10}, 1'b1, 1'b0, 1'b0, 0, 1);
    fetch({6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b1, 1'b0, 0, 0);
    total++;
    if (pc !== 32'h44) begin bad++; $display("FAIL beq_not_taken pc=%h want 00000044", pc); end
  endtask

  task automatic test_jump();
    fetch({6'h02, 26'h3FF_FFFF}, 1'b1, 1'b0, 1'b0, 0, 0);
    fetch({6'h02, 26'h0}, 1'b1, 1'b0, 1'b0, 1, 0);
    total++;
    if (pc !== 32'h1000_0000) begin bad++; $display("FAIL jump_region pc=%h want 10000000", pc); end
    fetch({6'h02, 26'h000_0100}, 1'b1, 1'b1, 1'b1, 0, 0);
    total++;
    if (pc !== 32'h1000_0400) begin bad++; $display("FAIL jump_priority pc=%h want 10000400", pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch({6'h04, 10'h0, 16'hFFFE}, 1'b0, 1'b1, 1'b1, 0, 0);
    total++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL top_pc pc=%h p4=%h want fffffffc 00000000", pc, pc_plus4);
    end
    fetch($urandom & 32'h03FF_FFFF, 1'b0, 1'b0, 1'b1, 0, 0);
    total++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL pc_wrap pc=%h addr=%h want 00000000", pc, imem_addr);
    end
  endtask

  task automatic test_count();
    do_reset();
    for (int i = 0; i < 17; i++)
      fetch($urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 1), 0);
    total++;
    if (instr_count !== 4'd1) begin bad++; $display("FAIL count_wrap cnt=%0d want 1", instr_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      fetch($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            (i < 8) ? 0 : $urandom_range(0, 3), (i < 8) ? 0 : $urandom_range(0, 2));
  endtask

  task automatic test_reset_hold();
    fetch($urandom, 1'b0, 1'b0, 1'b0, 0, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || pc === 32'h0) begin
      bad++; $display("FAIL pre_reset_hold valid=%b pc=%h want valid=1 pc!=0", instr_valid, pc);
    end
    retire = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 ||
        instr_count !== 4'd0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL async_reset valid=%b req=%b pc=%h instr=%h cnt=%0d want 0 0 0 0 0",
                      instr_valid, imem_req, pc, instr, instr_count);
    end
    @(negedge clk);
    total++;
    if (instr_count !== 4'd0 || pc !== 32'h0) begin
      bad++; $display("FAIL reset_no_retire pc=%h cnt=%0d want 0 0", pc, instr_count);
    end
    retire = 1'b0; rst_n = 1'b1;
    m_pc = 32'h0; m_cnt = 4'd0;
    fetch($urandom, 1'b0, 1'b0, 1'b0, 1, 0);
  endtask

  initial begin
    m_pc = 32'h0; m_cnt = 4'd0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_count();
    test_back_to_back();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule
